// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: shared formats, FSM encoding and word width for the instruction loader.
package instr_encoder_loader_pkg;
    localparam int XLEN = 32;
    typedef enum logic [1:0] {FMT_R = 2'd0, FMT_I = 2'd1, FMT_S = 2'd2, FMT_B = 2'd3} fmt_e;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-bundle handshake plus instruction-memory write bus.
interface instr_encoder_loader_if;
    import instr_encoder_loader_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      fmt;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [11:0]     imm;
    logic            last;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    modport master (output in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, last,
                    input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_valid, fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, last,
                    output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/instr_encoder_loader_encoder.sv
// instr_field_encoder: combinational R/I/S/B field packer, inverse of the instruction decoder.
module instr_field_encoder
    import instr_encoder_loader_pkg::*;
(
    input  logic [1:0]      fmt,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [4:0]      rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [11:0]     imm,
    output logic [XLEN-1:0] word
);
    // B imm carries offset[12:1], so imm[11] is the sign and imm[10] is offset bit 11
    assign word = fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode} :
                  fmt == FMT_I ? {imm, rs1, funct3, rd, opcode} :
                  fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} :
                                 {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], opcode};
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes field bundles and streams them into instruction memory.
// Optional running XOR checksum enabled by defining LOADER_CHECKSUM_EN.
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [XLEN-1:0]       base_addr,
    instr_encoder_loader_if.slave bus,
    output logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [XLEN-1:0]       checksum
);
    logic [1:0]      state;
    logic [XLEN-1:0] addr, maddr_q, wdata_q, enc;
    logic            we_q, last_q, last_seen, accept, cnt_hit, begin_s;
    instr_field_encoder u_enc (
        .fmt(bus.fmt), .opcode(bus.opcode), .funct3(bus.funct3), .funct7(bus.funct7),
        .rd(bus.rd), .rs1(bus.rs1), .rs2(bus.rs2), .imm(bus.imm), .word(enc)
    );
    // a word still in the write register counts against capacity
    assign bus.in_ready = state == S_LOAD && !last_seen &&
                          ({1'b0, count} + (CNT_W+1)'(we_q)) < (CNT_W+1)'(DEPTH);
    assign accept    = bus.in_valid && bus.in_ready;
    assign cnt_hit   = we_q && (count + 1'b1) == CNT_W'(DEPTH);
    assign begin_s   = state == S_IDLE && start;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = wdata_q;
    assign busy = state != S_IDLE;
    assign done = state == S_FINISH;
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            addr      <= '0;
            maddr_q   <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            last_q    <= 1'b0;
            last_seen <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            we_q   <= accept;
            last_q <= accept && bus.last;
            if (accept) begin
                wdata_q   <= enc;
                maddr_q   <= addr;
                addr      <= addr + 32'd4;
                last_seen <= last_seen | bus.last;
            end
            if (we_q)
                count <= count + 1'b1;
            if (begin_s) begin
                state     <= S_LOAD;
                addr      <= base_addr & ~32'd3;
                count     <= '0;
                overflow  <= 1'b0;
                last_seen <= 1'b0;
            end else if (state == S_LOAD && we_q && (last_q || cnt_hit)) begin
                state    <= S_FINISH;
                overflow <= !last_q;
            end else if (state == S_FINISH) begin
                state <= S_IDLE;
            end
        end
    end
`ifdef LOADER_CHECKSUM_EN
    logic [XLEN-1:0] csum;
    always_ff @(posedge clk) begin
        if (reset || begin_s)
            csum <= '0;
        else if (we_q)
            csum <= csum ^ wdata_q;
    end
    assign checksum = csum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, sequencing, overflow, reset and checksum.
module tb_instr_encoder_loader;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr;
    logic [2:0]  count;
    logic        busy, done, overflow;
    logic [31:0] checksum;
    int          n_checks = 0;
    int          n_fail = 0;
    int          nw, nd;
    instr_encoder_loader_if bus ();
    instr_encoder_loader #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .bus(bus),
        .count(count), .busy(busy), .done(done), .overflow(overflow), .checksum(checksum)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic bundle(input logic [1:0] f, input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [11:0] im, input logic l);
        bus.in_valid = 1'b1;
        bus.fmt = f; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
        bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im; bus.last = l;
    endtask
    task automatic begin_session(input logic [31:0] base);
        start = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask
    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0;
        bundle(2'd0, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 12'h0, 1'b0);
        bus.in_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        check("rst_wdata", bus.mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_csum", checksum, 32'd0);
        // in_valid while idle must not produce a write
        bus.in_valid = 1'b1;
        step();
        check("idle_ignore_we", 32'(bus.mem_we), 32'd0);
        bus.in_valid = 1'b0;
        // single R word, base low bits ignored
        begin_session(32'h103);
        check("r_busy", 32'(busy), 32'd1);
        check("r_ready", 32'(bus.in_ready), 32'd1);
        bundle(2'd0, 7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 12'h0, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("r_we", 32'(bus.mem_we), 32'd1);
        check("r_addr", bus.mem_addr, 32'h100);
        check("r_wdata", bus.mem_wdata, 32'h003100B3);
        check("r_ready_after_last", 32'(bus.in_ready), 32'd0);
        step();
        check("r_done", 32'(done), 32'd1);
        check("r_count", 32'(count), 32'd1);
        check("r_we_low", 32'(bus.mem_we), 32'd0);
        check("r_wdata_hold", bus.mem_wdata, 32'h003100B3);
        step();
        check("r_done_pulse", 32'(done), 32'd0);
        check("r_idle", 32'(busy), 32'd0);
        check("r_count_hold", 32'(count), 32'd1);
        check("r_ovf", 32'(overflow), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check("r_csum", checksum, 32'h003100B3);
`else
        check("r_csum", checksum, 32'h0);
`endif
        // I, S, B back to back
        begin_session(32'h200);
        bundle(2'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 12'hFFF, 1'b0);
        step();
        check("i_wdata", bus.mem_wdata, 32'hFFF00293);
        check("i_addr", bus.mem_addr, 32'h200);
        bundle(2'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd2, 5'd5, 12'd8, 1'b0);
        step();
        check("s_wdata", bus.mem_wdata, 32'h00512423);
        check("s_addr", bus.mem_addr, 32'h204);
        check("s_count", 32'(count), 32'd1);
        bundle(2'd3, 7'h63, 3'd1, 7'd0, 5'd0, 5'd1, 5'd2, 12'hC05, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("b_wdata", bus.mem_wdata, 32'h802095E3);
        check("b_addr", bus.mem_addr, 32'h208);
        check("b_we", 32'(bus.mem_we), 32'd1);
        step();
        check("isb_done", 32'(done), 32'd1);
        check("isb_count", 32'(count), 32'd3);
        step();
        // overflow at DEPTH=4, with a stray start mid-session
        begin_session(32'h0);
        bundle(2'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'h1, 1'b0);
        nw = 0; nd = 0;
        for (int i = 0; i < 8; i++) begin
            start = (i == 1);
            step();
            if (bus.mem_we) begin
                check("ovf_addr", bus.mem_addr, 32'(nw * 4));
                nw++;
            end
            if (done) nd++;
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        check("ovf_writes", 32'(nw), 32'd4);
        check("ovf_done_cnt", 32'(nd), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_ready", 32'(bus.in_ready), 32'd0);
        check("ovf_idle", 32'(busy), 32'd0);
        // reset right after an accept
        begin_session(32'h40);
        bundle(2'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'h0, 1'b0);
        step();
        check("pre_rst_we", 32'(bus.mem_we), 32'd1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_addr", bus.mem_addr, 32'd0);
        check("mid_rst_wdata", bus.mem_wdata, 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_csum", checksum, 32'd0);
        // checksum session, also proves a fresh start works after reset
        begin_session(32'h80);
        bundle(2'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'h0, 1'b0);
        step();
        check("cs_w0", bus.mem_wdata, 32'h00000013);
        check("cs_a0", bus.mem_addr, 32'h80);
        bundle(2'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 12'h1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        check("cs_w1", bus.mem_wdata, 32'h00100093);
        check("cs_a1", bus.mem_addr, 32'h84);
        step();
        check("cs_done", 32'(done), 32'd1);
        step();
        check("cs_count", 32'(count), 32'd2);
`ifdef LOADER_CHECKSUM_EN
        check("cs_csum", checksum, 32'h00100080);
`else
        check("cs_csum", checksum, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
